rle_decompressor: RTL
=====================

// Module: rle_decompressor
// PURPOSE
//  On-chip run-length decoder for compressed ATPG test data: the stage directly downstream of the
//  run-length encoder. Consumes (code, run_length) pairs and re-expands each one into run_length
//  consecutive copies of code, streamed out one pattern per cycle under valid/ready flow control.
//  Feeds the scan-load / pattern-decode logic; keeps a saturating count of patterns emitted.
// PARAMETERS
//  CODE_W  4   width of an encoded pattern symbol
//  RUN_W   4   width of the run-length field (max run = 2**RUN_W-1)
//  CNT_W   16  width of the emitted-pattern statistics counter
// PORTS
//  clk           in   1       system clock, rising edge
//  reset         in   1       asynchronous, active-high reset
//  in_valid      in   1       upstream pair valid
//  in_ready      out  1       block accepts pair this cycle (transfer = in_valid & in_ready)
//  in_code       in   CODE_W  symbol to repeat
//  in_run        in   RUN_W   repeat count for in_code
//  out_valid     out  1       out_code valid
//  out_ready     in   1       downstream accepts out_code (transfer = out_valid & out_ready)
//  out_code      out  CODE_W  expanded pattern symbol
//  busy          out  1       high while a run is being expanded (state EXPAND)
//  zero_run_err  out  1       sticky: a pair with in_run==0 was consumed
//  sym_count     out  CNT_W   patterns emitted since reset, saturating at all-ones
// BEHAVIOUR
//  - One clock domain; reset is asynchronous and active-high; all state clears on reset assertion.
//  - Reset values: out_valid=0, out_code=0, busy=0, zero_run_err=0, sym_count=0, state=IDLE,
//    remaining=0; in_ready=1 once reset is released.
//  - State machine: IDLE, EXPAND. Internal remaining counter is RUN_W bits.
//  - in_ready = (state==IDLE) | (state==EXPAND & remaining==1 & out_ready). Combinational path
//    out_ready->in_ready is intentional: it gives gap-free back-to-back runs.
//  - IDLE: on transfer with in_run!=0: latch out_code<=in_code, remaining<=in_run, go EXPAND.
//    First out_valid the following cycle (1-cycle latency accept->first pattern).
//  - IDLE, transfer with in_run==0: pair discarded, zero_run_err<=1, stay IDLE, no output.
//  - EXPAND: out_valid=1, busy=1. out_code and out_valid held stable while out_ready=0.
//  - Each output transfer: remaining<=remaining-1, sym_count<=sym_count+1 unless already all-ones.
//  - Output transfer with remaining==1 (last beat):
//      in_valid & in_run!=0 -> load next pair same edge, stay EXPAND (no bubble);
//      in_valid & in_run==0 -> consume, set zero_run_err, go IDLE;
//      !in_valid            -> go IDLE, out_valid=0 next cycle.
//  - Max run (in_run=2**RUN_W-1) yields exactly that many beats; no wrap of remaining.
//  - in_code/in_run are ignored when no input transfer occurs; no pair is ever dropped or duplicated.
//  - zero_run_err clears only on reset. sym_count never wraps.
//  - Reset mid-run: run abandoned at once, out_valid falls asynchronously, no residual beats after
//    release.
// TESTING
//  1. Assert reset -> out_valid=0, out_code=0, busy=0, zero_run_err=0, sym_count=0; release -> in_ready=1.
//  2. Pair (A,3), out_ready=1 -> out_code=A valid cycles 1..3, in_ready=1 in cycle 3, IDLE cycle 4,
//     sym_count=3.
//  3. Pairs (5,2),(7,1) presented back-to-back, out_ready=1 -> output 5,5,7 on consecutive cycles,
//     no bubble, sym_count=3.
//  4. Pair (C,2), out_ready=0 for 4 cycles then 1 -> out_code=C held, in_ready=0, sym_count unchanged
//     while stalled; then two beats.
//  5. Pair (9,0) then (9,1) -> no output for first pair, zero_run_err=1 and stays 1, one beat of 9 follows.
//  6. Pair (3,15), assert reset after 5 beats -> out_valid=0 immediately, sym_count=0; after release
//     no further beats of 3.

Source files
------------

// File: rtl/rle_decompressor.sv
// Run-length decoder: expands (code, run) pairs into run copies of code, one per cycle,
// under valid/ready flow control, with a sticky zero-run flag and a saturating beat counter.
module rle_decompressor #(
    parameter int CODE_W = 4,
    parameter int RUN_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [RUN_W-1:0]  in_run,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              busy,
    output logic              zero_run_err,
    output logic [CNT_W-1:0]  sym_count
);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t           state;
    logic [RUN_W-1:0] remaining;
    logic             last_beat;
    logic             in_xfer;
    logic             out_xfer;

    // Ready during the last beat lets the next pair load on the same edge, so runs abut.
    assign last_beat = (state == EXPAND) && (remaining == RUN_W'(1)) && out_ready;
    assign in_ready  = (state == IDLE) || last_beat;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            out_code     <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            zero_run_err <= 1'b0;
            sym_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        if (in_run != '0) begin
                            out_code  <= in_code;
                            remaining <= in_run;
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= EXPAND;
                        end else begin
                            zero_run_err <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    if (out_xfer) begin
                        remaining <= remaining - RUN_W'(1);
                        if (sym_count != {CNT_W{1'b1}})
                            sym_count <= sym_count + CNT_W'(1);
                        if (remaining == RUN_W'(1)) begin
                            if (in_xfer && (in_run != '0)) begin
                                out_code  <= in_code;
                                remaining <= in_run;
                            end else begin
                                if (in_xfer)
                                    zero_run_err <= 1'b1;
                                out_valid <= 1'b0;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
